rrat_multi_commit: RTL
======================

// Module: rrat_multi_commit
// PURPOSE
//  Retirement RAT for an N-wide commit stage. Holds the committed arch->phys map.
//  Each cycle it accepts up to COMMIT_WIDTH retiring writes from the ROB and returns
//  each displaced (stale) phys reg to the free list. Intra-group same-rd commits are
//  resolved in program order. Exports the map for front-end RAT recovery on flush.
// PARAMETERS
//  NUM_PHYS_REG  64  physical register count; PW = $clog2(NUM_PHYS_REG)
//  NUM_ARCH_REG  32  architectural register count; AW = $clog2(NUM_ARCH_REG)
//  COMMIT_WIDTH  2   retire ports per cycle; slot 0 is oldest
// PORTS
//  clk             in   1           clock
//  rst             in   1           reset, asynchronous, active-high
//  commit_valid    in   [W]         slot i retires an instruction with rd writeback
//  commit_rd       in   [W][AW]     arch destination of slot i
//  commit_pd       in   [W][PW]     new phys destination of slot i
//  free_valid      out  [W]         registered: free_pd[i] goes to free list this cycle
//  free_pd         out  [W][PW]     registered stale phys reg for slot i
//  rrat_map_out    out  [NA][PW]    current committed map (register contents)
//  retired_count   out  32          retired-writeback perf counter
// BEHAVIOUR
//  - Reset (async, any cycle): map[r] <= r for all r; free_valid <= 0; free_pd <= 0;
//    retired_count <= 0. Reset mid-group drops the in-flight group; no frees emitted.
//  - Effective slot: eff[i] = commit_valid[i] && commit_rd[i] != 0. Slots with rd==0
//    are ignored: no map write, no free, not counted.
//  - Stale pd for eff slot i: pd of the highest j<i with eff[j] and rd[j]==rd[i];
//    if none, map[rd[i]] as held at the start of the cycle.
//  - Map update at posedge: for each rd, the highest eff slot writing it wins.
//  - Latency: free_valid/free_pd appear 1 cycle after commit, same edge the map updates.
//    free_valid[i] <= eff[i]; free_pd[i] <= stale[i]. Non-eff slots keep free_pd unchanged.
//  - retired_count += popcount(eff) per cycle; wraps modulo 2^32.
//  - No backpressure: free list must accept W enqueues every cycle.
//  - Gaps allowed: commit_valid need not be contiguous from slot 0; order is by index.
//  - rrat_map_out always reflects the post-update register state (no bypass of this
//    cycle's commits).
//  - Sim-only assertion: no two map entries hold the same pd (outside reset).
// STRUCTURE
//  - Shared package params: NUM_PHYS_REG, NUM_ARCH_REG, COMMIT_WIDTH.
//  - Shared package rv32i_types: rrat_commit_t {logic valid; logic [AW-1:0] rd;
//    logic [PW-1:0] pd;}. Ports may be arrays of it.
//  - Sub-module rrat_group_resolve: combinational; takes the W commits and a map
//    snapshot; outputs eff[W], stale[W], per-rd final write enable/value.
//    Top level holds the map flops, the free-output regs and the counter.
// TESTING
//  1. Reset -> rrat_map_out[r]==r for all r; free_valid==0; retired_count==0.
//  2. Slot0 {rd=5,pd=40} -> next cycle free_valid=01, free_pd[0]=5; map[5]==40; count=1.
//  3. Same cycle slot0 {rd=7,pd=33}, slot1 {rd=7,pd=34} -> free_pd={33,7},
//     free_valid=11, map[7]==34, count=2.
//  4. Slot0 {rd=0,pd=50}, slot1 {rd=3,pd=51} -> free_valid=10, free_pd[1]=3,
//     map[0]==0, map[3]==51, count=1.
//  5. Back-to-back cycles with rd=9 -> pd 60, then rd=9 -> pd 61 -> 2nd free_pd=60,
//     map[9]==61.
//  6. Commit {rd=4,pd=45} and assert rst asynchronously mid-cycle -> map[4]==4
//     immediately, no free_valid pulse; random W-wide stream vs model, pd-uniqueness holds.

Source files
------------

// File: rtl/rrat_multi_commit_pkg.sv
// rrat_multi_commit_pkg: shared sizes, commit record type and helpers for the retirement RAT
package rrat_multi_commit_pkg;
    localparam int NUM_PHYS_REG = 64;
    localparam int NUM_ARCH_REG = 32;
    localparam int COMMIT_WIDTH = 2;
    localparam int PW = $clog2(NUM_PHYS_REG);
    localparam int AW = $clog2(NUM_ARCH_REG);

    typedef logic [PW-1:0] preg_t;
    typedef logic [AW-1:0] areg_t;
    typedef preg_t [NUM_ARCH_REG-1:0] map_t;

    typedef struct packed {
        logic  valid;
        areg_t rd;
        preg_t pd;
    } rrat_commit_t;

    typedef rrat_commit_t [COMMIT_WIDTH-1:0] commit_grp_t;

    function automatic logic [31:0] popcount(input logic [COMMIT_WIDTH-1:0] v);
        popcount = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) popcount += 32'(v[i]);
    endfunction

    function automatic map_t identity_map();
        for (int r = 0; r < NUM_ARCH_REG; r++) identity_map[r] = PW'(r);
    endfunction
endpackage

// File: rtl/rrat_multi_commit_if.sv
// rrat_multi_commit_if: commit group in, frees / committed map / perf counter out
interface rrat_multi_commit_if;
    import rrat_multi_commit_pkg::*;
    commit_grp_t                   commit;
    logic [COMMIT_WIDTH-1:0]       free_valid;
    preg_t [COMMIT_WIDTH-1:0]      free_pd;
    map_t                          rrat_map_out;
    logic [31:0]                   retired_count;

    modport master (output commit, input free_valid, free_pd, rrat_map_out, retired_count);
    modport slave  (input commit, output free_valid, free_pd, rrat_map_out, retired_count);
endinterface

// File: rtl/rrat_group_resolve.sv
// rrat_group_resolve: program-order resolution of one commit group against a map snapshot
module rrat_group_resolve
    import rrat_multi_commit_pkg::*;
(
    input  commit_grp_t              commit_i,
    input  map_t                     map_i,
    output logic [COMMIT_WIDTH-1:0]  eff_o,
    output preg_t [COMMIT_WIDTH-1:0] stale_o,
    output logic [NUM_ARCH_REG-1:0]  wr_en_o,
    output map_t                     wr_pd_o
);
    map_t run;

    // Walk slots oldest first: each slot sees the map as left by the older slots, so its
    // stale pd is the younger-most earlier same-rd write, else the snapshot entry.
    always_comb begin
        run     = map_i;
        eff_o   = '0;
        stale_o = '0;
        wr_en_o = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            eff_o[i]   = commit_i[i].valid && commit_i[i].rd != '0;
            stale_o[i] = run[commit_i[i].rd];
            if (eff_o[i]) begin
                wr_en_o[commit_i[i].rd] = 1'b1;
                run[commit_i[i].rd]     = commit_i[i].pd;
            end
        end
        wr_pd_o = run;
    end
endmodule

// File: rtl/rrat_multi_commit.sv
// rrat_multi_commit: retirement RAT holding the committed arch->phys map for an N-wide commit
module rrat_multi_commit
    import rrat_multi_commit_pkg::*;
(
    input logic                clk,
    input logic                rst,
    rrat_multi_commit_if.slave bus
);
    map_t                     map_q, map_d, wr_pd;
    logic [NUM_ARCH_REG-1:0]  wr_en;
    logic [COMMIT_WIDTH-1:0]  eff, free_valid_q, free_valid_d;
    preg_t [COMMIT_WIDTH-1:0] stale, free_pd_q, free_pd_d;
    logic [31:0]              count_q, count_d;

    rrat_group_resolve u_resolve (
        .commit_i (bus.commit),
        .map_i    (map_q),
        .eff_o    (eff),
        .stale_o  (stale),
        .wr_en_o  (wr_en),
        .wr_pd_o  (wr_pd)
    );

    // Next state: merge group writes into the map, latch stale pds for effective slots only
    always_comb begin
        for (int r = 0; r < NUM_ARCH_REG; r++) map_d[r] = wr_en[r] ? wr_pd[r] : map_q[r];
        for (int i = 0; i < COMMIT_WIDTH; i++) free_pd_d[i] = eff[i] ? stale[i] : free_pd_q[i];
        free_valid_d = eff;
        count_d      = count_q + popcount(eff);
    end

    // State registers; reset drops any in-flight group
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            map_q        <= identity_map();
            free_valid_q <= '0;
            free_pd_q    <= '0;
            count_q      <= '0;
        end else begin
            map_q        <= map_d;
            free_valid_q <= free_valid_d;
            free_pd_q    <= free_pd_d;
            count_q      <= count_d;
        end
    end

    assign bus.rrat_map_out  = map_q;
    assign bus.free_valid    = free_valid_q;
    assign bus.free_pd       = free_pd_q;
    assign bus.retired_count = count_q;

    // Every committed phys reg must be owned by exactly one arch reg
    always_ff @(posedge clk) begin
        if (!rst)
            for (int i = 0; i < NUM_ARCH_REG; i++)
                for (int j = i + 1; j < NUM_ARCH_REG; j++)
                    assert (map_q[i] != map_q[j]);
    end
endmodule
